// File: rtl/eeprom_seq_if.sv
// Byte-level link between the EEPROM command sequencer (master) and the SPI
// byte engine (slave).
interface eeprom_seq_if;
   // Handshake: the master raises eng_frame, then pulses eng_write or eng_read
   // for exactly one cycle. The slave answers with a level complete flag. The
   // master waits for complete=1, then waits for complete=0 before it issues
   // the next pulse. eng_wdata holds its value from the pulse until completion.
   logic       eng_frame;
   logic       eng_write;
   logic [7:0] eng_wdata;
   logic       eng_write_complete;
   logic       eng_read;
   logic [7:0] eng_read_value;
   logic       eng_read_complete;

   modport master (
      output eng_frame, eng_write, eng_wdata, eng_read,
      input  eng_write_complete, eng_read_value, eng_read_complete
   );

   modport slave (
      input  eng_frame, eng_write, eng_wdata, eng_read,
      output eng_write_complete, eng_read_value, eng_read_complete
   );
endinterface

// File: rtl/eeprom_seq.sv
// Command sequencer for the M25AA010A: expands one host byte read or write into
// WREN / WRITE / RDSR-poll or READ frames over the SPI byte engine handshake.
module eeprom_seq #(
   parameter int GAP_CYCLES = 50,
   parameter int POLL_GAP   = 5000,
   parameter int MAX_POLLS  = 100
) (
   input  logic         clk_50M,
   input  logic         reset,
   input  logic         req,
   input  logic         req_we,
   input  logic [6:0]   req_addr,
   input  logic [7:0]   req_wdata,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [7:0]   rdata,
   eeprom_seq_if.master bus,
   output logic [3:0]   dbg_state
);

   localparam int GAP_MAX = (GAP_CYCLES > POLL_GAP) ? GAP_CYCLES : POLL_GAP;
   localparam int CW      = $clog2(GAP_MAX + 1);
   localparam int PW      = $clog2(MAX_POLLS + 1);

   localparam logic [CW-1:0] GAP_SAT  = CW'(GAP_MAX);
   localparam logic [CW-1:0] GAP_THR  = CW'(GAP_CYCLES - 1);
   localparam logic [CW-1:0] POLL_THR = CW'(POLL_GAP - 1);
   localparam logic [PW-1:0] POLL_SAT = PW'(MAX_POLLS);

   typedef enum logic [3:0] {
      S_IDLE, S_WREN, S_GAP_A, S_WR_CMD, S_WR_ADDR, S_WR_DATA, S_GAP_B,
      S_POLL_CMD, S_POLL_RD, S_POLL_WAIT, S_RD_CMD, S_RD_ADDR, S_RD_DATA, S_FINISH
   } state_t;

   // START only precedes the first frame of a request: it enforces the gap
   // since the last frame fall (or reset) before eng_frame may rise.
   typedef enum logic [1:0] {PH_START, PH_ISSUE, PH_WAIT, PH_RELEASE} phase_t;

   state_t        state;
   phase_t        phase;
   logic [7:0]    addr_q;
   logic [7:0]    wdata_q;
   logic          wip_q;
   logic [CW-1:0] gap_cnt;
   logic [PW-1:0] poll_cnt;

   logic [7:0]    tx_byte;
   logic          byte_rd;
   logic          byte_last;
   logic          cmpl;
   state_t        next_st;

   assign dbg_state = state;

   always_comb begin
      tx_byte   = 8'h00;
      byte_rd   = 1'b0;
      byte_last = 1'b0;
      next_st   = S_IDLE;
      case (state)
         S_WREN:     begin tx_byte = 8'h06; byte_last = 1'b1; next_st = S_GAP_A;   end
         S_WR_CMD:   begin tx_byte = 8'h02;                   next_st = S_WR_ADDR; end
         S_WR_ADDR:  begin tx_byte = addr_q;                  next_st = S_WR_DATA; end
         S_WR_DATA:  begin tx_byte = wdata_q; byte_last = 1'b1; next_st = S_GAP_B; end
         S_POLL_CMD: begin tx_byte = 8'h05;                   next_st = S_POLL_RD; end
         S_POLL_RD:  begin byte_rd = 1'b1; byte_last = 1'b1;  next_st = S_FINISH;  end
         S_RD_CMD:   begin tx_byte = 8'h03;                   next_st = S_RD_ADDR; end
         S_RD_ADDR:  begin tx_byte = addr_q;                  next_st = S_RD_DATA; end
         S_RD_DATA:  begin byte_rd = 1'b1; byte_last = 1'b1;  next_st = S_FINISH;  end
         default:    begin tx_byte = 8'h00;                   next_st = S_IDLE;    end
      endcase
      cmpl = byte_rd ? bus.eng_read_complete : bus.eng_write_complete;
   end

   always_ff @(posedge clk_50M or posedge reset) begin
      if (reset) begin
         state         <= S_IDLE;
         phase         <= PH_START;
         busy          <= 1'b0;
         done          <= 1'b0;
         err           <= 1'b0;
         rdata         <= 8'h00;
         bus.eng_frame <= 1'b0;
         bus.eng_write <= 1'b0;
         bus.eng_read  <= 1'b0;
         bus.eng_wdata <= 8'h00;
         addr_q        <= 8'h00;
         wdata_q       <= 8'h00;
         wip_q         <= 1'b0;
         gap_cnt       <= '0;
         poll_cnt      <= '0;
      end else begin
         done          <= 1'b0;
         bus.eng_write <= 1'b0;
         bus.eng_read  <= 1'b0;
         // Counts low cycles since the last frame fall; restarted on each fall.
         if (gap_cnt != GAP_SAT) gap_cnt <= gap_cnt + 1'b1;
         case (state)
            S_IDLE: begin
               if (req) begin
                  addr_q   <= {1'b0, req_addr};
                  wdata_q  <= req_wdata;
                  busy     <= 1'b1;
                  err      <= 1'b0;
                  poll_cnt <= '0;
                  phase    <= PH_START;
                  state    <= req_we ? S_WREN : S_RD_CMD;
               end
            end
            S_GAP_A: begin
               if (gap_cnt >= GAP_THR) begin
                  bus.eng_frame <= 1'b1;
                  phase         <= PH_ISSUE;
                  state         <= S_WR_CMD;
               end
            end
            S_GAP_B: begin
               if (gap_cnt >= GAP_THR) begin
                  bus.eng_frame <= 1'b1;
                  phase         <= PH_ISSUE;
                  state         <= S_POLL_CMD;
               end
            end
            S_POLL_WAIT: begin
               if (gap_cnt >= POLL_THR) begin
                  bus.eng_frame <= 1'b1;
                  phase         <= PH_ISSUE;
                  state         <= S_POLL_CMD;
               end
            end
            S_FINISH: begin
               busy  <= 1'b0;
               state <= S_IDLE;
            end
            S_WREN, S_WR_CMD, S_WR_ADDR, S_WR_DATA, S_POLL_CMD, S_POLL_RD,
            S_RD_CMD, S_RD_ADDR, S_RD_DATA: begin
               case (phase)
                  PH_START: begin
                     if (gap_cnt >= GAP_THR) begin
                        bus.eng_frame <= 1'b1;
                        phase         <= PH_ISSUE;
                     end
                  end
                  PH_ISSUE: begin
                     if (byte_rd) begin
                        bus.eng_read <= 1'b1;
                     end else begin
                        bus.eng_write <= 1'b1;
                        bus.eng_wdata <= tx_byte;
                     end
                     phase <= PH_WAIT;
                  end
                  PH_WAIT: begin
                     if (cmpl) begin
                        if (state == S_POLL_RD) begin
                           wip_q <= bus.eng_read_value[0];
                           if (bus.eng_read_value[0] && poll_cnt != POLL_SAT)
                              poll_cnt <= poll_cnt + 1'b1;
                        end
                        if (state == S_RD_DATA) rdata <= bus.eng_read_value;
                        if (byte_last) begin
                           bus.eng_frame <= 1'b0;
                           gap_cnt       <= '0;
                        end
                        phase <= PH_RELEASE;
                     end
                  end
                  PH_RELEASE: begin
                     if (!cmpl) begin
                        phase <= PH_ISSUE;
                        if (state == S_POLL_RD) begin
                           if (!wip_q) begin
                              done  <= 1'b1;
                              err   <= 1'b0;
                              state <= S_FINISH;
                           end else if (poll_cnt >= POLL_SAT) begin
                              done  <= 1'b1;
                              err   <= 1'b1;
                              state <= S_FINISH;
                           end else begin
                              state <= S_POLL_WAIT;
                           end
                        end else if (next_st == S_FINISH) begin
                           done  <= 1'b1;
                           err   <= 1'b0;
                           state <= S_FINISH;
                        end else begin
                           state <= next_st;
                        end
                     end
                  end
               endcase
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_eeprom_seq.sv
// Bench for eeprom_seq: byte engine plus M25AA010A behavioural model, random
// host traffic, frame/gap/poll checks and a read-data scoreboard.
module tb_eeprom_seq;

   localparam int GAP  = 50;
   localparam int PGAP = 200;
   localparam int MAXP = 3;

   logic       clk_50M = 1'b0;
   logic       reset   = 1'b1;
   logic       req     = 1'b0;
   logic       req_we  = 1'b0;
   logic [6:0] req_addr  = 7'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       busy, done, err;
   logic [7:0] rdata;
   logic [3:0] dbg_state;

   eeprom_seq_if bus();

   eeprom_seq #(.GAP_CYCLES(GAP), .POLL_GAP(PGAP), .MAX_POLLS(MAXP)) dut (
      .clk_50M   (clk_50M),
      .reset     (reset),
      .req       (req),
      .req_we    (req_we),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .rdata     (rdata),
      .bus       (bus),
      .dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   always #5 clk_50M = ~clk_50M;

   initial begin
      #900000;
      $display("FAIL watchdog: got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard / counters ----------------
   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] ref_mem[128];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // ---------------- engine + EEPROM model ----------------
   logic [7:0] mem[128];
   bit         wel, wip, stuck_wip;
   int         wip_left, wip_time;
   int         pend, hold;
   bit         pend_rd;
   logic [7:0] pend_val;
   logic [7:0] frame_q[$];
   bit         prev_frame, prev_write;
   int         low_len, viol, n_done;
   logic [7:0] f_op[$], f_b1[$], f_b2[$], st_q[$];
   int         f_len[$], f_low[$];

   task automatic frame_end();
      f_op.push_back(frame_q.size() > 0 ? frame_q[0] : 8'h00);
      f_b1.push_back(frame_q.size() > 1 ? frame_q[1] : 8'h00);
      f_b2.push_back(frame_q.size() > 2 ? frame_q[2] : 8'h00);
      f_len.push_back(frame_q.size());
      if (frame_q.size() == 1 && frame_q[0] == 8'h06) wel = 1'b1;
      if (frame_q.size() == 3 && frame_q[0] == 8'h02 && wel) begin
         mem[frame_q[1][6:0]] = frame_q[2];
         wel = 1'b0;
         wip = 1'b1;
         wip_left = wip_time;
      end
      frame_q.delete();
   endtask

   initial begin : engine_model
      logic [7:0] v;
      bus.eng_write_complete = 1'b0;
      bus.eng_read_complete  = 1'b0;
      bus.eng_read_value     = 8'h00;
      forever begin
         @(negedge clk_50M);
         if (reset) begin
            bus.eng_write_complete = 1'b0;
            bus.eng_read_complete  = 1'b0;
            pend = 0; hold = 0; frame_q.delete();
            prev_frame = 1'b0; prev_write = 1'b0; low_len = 0;
         end else begin
            if (wip && !stuck_wip) begin
               if (wip_left > 0) wip_left--;
               if (wip_left == 0) wip = 1'b0;
            end
            if (hold > 0) begin
               hold--;
               if (hold == 0) begin
                  bus.eng_write_complete = 1'b0;
                  bus.eng_read_complete  = 1'b0;
               end
            end
            if (pend > 0) begin
               pend--;
               if (pend == 0) begin
                  if (pend_rd) begin
                     bus.eng_read_value    = pend_val;
                     bus.eng_read_complete = 1'b1;
                  end else begin
                     bus.eng_write_complete = 1'b1;
                  end
                  hold = $urandom_range(1, 3);
               end
            end
            if (bus.eng_write) begin
               if (prev_write || !bus.eng_frame) viol++;
               frame_q.push_back(bus.eng_wdata);
               pend = $urandom_range(1, 8);
               pend_rd = 1'b0;
            end
            if (bus.eng_read) begin
               if (!bus.eng_frame) viol++;
               v = 8'h00;
               if (frame_q.size() == 2 && frame_q[0] == 8'h03) v = mem[frame_q[1][6:0]];
               if (frame_q.size() == 1 && frame_q[0] == 8'h05) begin
                  v = stuck_wip ? 8'h01 : {6'b0, wel, wip};
                  st_q.push_back(v);
               end
               frame_q.push_back(v);
               pend = $urandom_range(1, 8);
               pend_rd = 1'b1;
               pend_val = v;
            end
            if (bus.eng_frame && !prev_frame) f_low.push_back(low_len);
            if (!bus.eng_frame && prev_frame) frame_end();
            low_len = bus.eng_frame ? 0 : low_len + 1;
            prev_frame = bus.eng_frame;
            prev_write = bus.eng_write;
         end
      end
   end

   always @(negedge clk_50M) if (!reset && done) n_done++;

   // ---------------- driver tasks ----------------
   task automatic start_req(input logic we, input logic [6:0] a, input logic [7:0] d);
      int n;
      n = 0;
      @(negedge clk_50M);
      while (busy && n < 5000) begin @(negedge clk_50M); n++; end
      chk("idle_before_req", busy, 0);
      f_op.delete(); f_b1.delete(); f_b2.delete(); f_len.delete(); f_low.delete(); st_q.delete();
      req = 1'b1; req_we = we; req_addr = a; req_wdata = d;
      @(negedge clk_50M);
      req = 1'b0;
      chk("busy_after_req", busy, 1);
   endtask

   task automatic finish_req(output logic e, output logic [7:0] rd);
      int n;
      n = 0;
      while (!done && n < 20000) begin @(negedge clk_50M); n++; end
      chk("done_seen", done, 1);
      chk("busy_at_done", busy, 1);
      e  = err;
      rd = rdata;
      @(negedge clk_50M);
      chk("busy_after_done", busy, 0);
      chk("done_one_cycle", done, 0);
   endtask

   task automatic check_write_log(input logic [6:0] a, input logic [7:0] d, input logic e);
      bit ok, gap_ok, exp_err;
      int exp_polls;
      ok = (f_op.size() >= 3);
      if (ok) ok = f_op[0] == 8'h06 && f_len[0] == 1 && f_op[1] == 8'h02 && f_len[1] == 3
                   && f_b1[1] == {1'b0, a} && f_b2[1] == d;
      for (int i = 2; i < f_op.size(); i++)
         if (f_op[i] != 8'h05 || f_len[i] != 2) ok = 1'b0;
      chk("wr_frame_seq", ok, 1);
      exp_polls = MAXP;
      exp_err   = 1'b1;
      for (int i = 0; i < st_q.size(); i++) begin
         if (!st_q[i][0]) begin exp_polls = i + 1; exp_err = 1'b0; break; end
      end
      chk("poll_count", f_op.size() - 2, exp_polls);
      chk("wr_err", e, exp_err);
      if (f_low.size() >= 3) begin
         chk("gap_wren_write", f_low[1], GAP);
         chk("gap_write_poll", f_low[2], GAP);
         gap_ok = 1'b1;
         for (int i = 3; i < f_low.size(); i++) if (f_low[i] != PGAP) gap_ok = 1'b0;
         chk("gap_poll_poll", gap_ok, 1);
      end else begin
         chk("gap_frames_seen", f_low.size(), 3);
      end
   endtask

   task automatic do_write(input logic [6:0] a, input logic [7:0] d, input int wt, output logic e);
      logic [7:0] rd;
      wip_time = wt;
      start_req(1'b1, a, d);
      finish_req(e, rd);
      ref_mem[a] = d;
      check_write_log(a, d, e);
   endtask

   task automatic do_read(input logic [6:0] a);
      logic       e;
      logic [7:0] rd;
      exp_q.push_back(ref_mem[a]);
      start_req(1'b0, a, 8'h00);
      finish_req(e, rd);
      chk("rd_err", e, 0);
      chk("rd_frame", (f_op.size() == 1 && f_op[0] == 8'h03 && f_len[0] == 3
                       && f_b1[0] == {1'b0, a}) ? 1 : 0, 1);
      chk("rdata", rd, exp_q.pop_front());
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic e;
      int   n, d0;
      for (int i = 0; i < 128; i++) begin mem[i] = 8'hFF; ref_mem[i] = 8'hFF; end
      wel = 0; wip = 0; stuck_wip = 0; wip_left = 0; wip_time = 100;
      viol = 0; n_done = 0;

      repeat (3) @(negedge clk_50M);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_err", err, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_frame", bus.eng_frame, 0);
      chk("rst_write", bus.eng_write, 0);
      chk("rst_read", bus.eng_read, 0);
      chk("rst_wdata", bus.eng_wdata, 0);
      reset = 1'b0;

      // write then read back
      do_write(7'h00, 8'h12, 150, e);
      chk("first_write_err", e, 0);
      chk("mem00", mem[0], 8'h12);
      do_read(7'h00);

      // randomized traffic
      for (int k = 0; k < 8; k++) begin
         if ($urandom_range(0, 1) == 1)
            do_write(7'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), $urandom_range(20, 700), e);
         else
            do_read(7'($urandom_range(0, 7)));
      end

      // poll timeout
      stuck_wip = 1'b1;
      do_write(7'h05, 8'hA5, 100, e);
      chk("timeout_err", e, 1);
      stuck_wip = 1'b0;
      wip = 1'b0;

      // request while busy is ignored
      d0 = n_done;
      start_req(1'b1, 7'h02, 8'h77);
      wip_time = 100;
      n = 0;
      while (!(frame_q.size() == 2 && frame_q[0] == 8'h02) && n < 3000) begin
         @(negedge clk_50M); n++;
      end
      chk("reach_wr_addr", (n < 3000) ? 1 : 0, 1);
      req = 1'b1; req_we = 1'b1; req_addr = 7'h01; req_wdata = 8'h34;
      @(negedge clk_50M);
      req = 1'b0;
      finish_req(e, pend_val);
      ref_mem[2] = 8'h77;
      check_write_log(7'h02, 8'h77, e);
      repeat (300) @(negedge clk_50M);
      chk("single_done", n_done - d0, 1);
      chk("mem01_kept", mem[1], ref_mem[1]);
      do_read(7'h02);

      // asynchronous reset during WR_DATA
      start_req(1'b1, 7'h03, 8'h55);
      n = 0;
      while (!(frame_q.size() == 3 && frame_q[0] == 8'h02) && n < 3000) begin
         @(negedge clk_50M); n++;
      end
      chk("reach_wr_data", (n < 3000) ? 1 : 0, 1);
      #2 reset = 1'b1;
      #1;
      chk("rst_mid_frame", bus.eng_frame, 0);
      chk("rst_mid_busy", busy, 0);
      repeat (3) @(negedge clk_50M);
      reset = 1'b0;
      do_write(7'h01, 8'h34, 100, e);
      chk("mem01_after_rst", mem[1], 8'h34);
      do_read(7'h01);
      do_read(7'h03);

      chk("pulse_rules", viol, 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
